// File: rtl/otbn_mont_vec_seq_if.sv
// Bundle of the sequencer's control, operand and result signals, and the port pair it uses to
// reach the shared Montgomery multiplier.
interface otbn_mont_vec_seq_if #(
  parameter int unsigned WLEN       = 256,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LOG_R      = 32
);
  logic                  start;
  logic                  bcast;
  logic [WLEN-1:0]       op0;
  logic [WLEN-1:0]       op1;
  logic [DATA_WIDTH-1:0] q;
  logic [LOG_R-1:0]      q_dash;
  logic                  busy;
  logic                  done;
  logic [WLEN-1:0]       res;

  logic                  mul_req;
  logic                  mul_gnt;
  logic [DATA_WIDTH-1:0] mul_op0;
  logic [DATA_WIDTH-1:0] mul_op1;
  logic [DATA_WIDTH-1:0] mul_q;
  logic [LOG_R-1:0]      mul_q_dash;
  logic [DATA_WIDTH-1:0] mul_res;

  // The master side is the vector decode plus the multiplier arbitration and datapath.
  modport master (
    output start, bcast, op0, op1, q, q_dash, mul_gnt, mul_res,
    input  busy, done, res, mul_req, mul_op0, mul_op1, mul_q, mul_q_dash
  );

  modport slave (
    input  start, bcast, op0, op1, q, q_dash, mul_gnt, mul_res,
    output busy, done, res, mul_req, mul_op0, mul_op1, mul_q, mul_q_dash
  );
endinterface

// File: rtl/otbn_mont_vec_seq.sv
// Lane-wise Montgomery vector product: issues one lane per granted cycle to a shared,
// combinational Montgomery multiplier and collects the results into a WLEN-bit vector.
module otbn_mont_vec_seq #(
  parameter int unsigned WLEN       = 256,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LOG_R      = 32
) (
  input logic                clk,
  input logic                rst,
  otbn_mont_vec_seq_if.slave bus
);
  localparam int unsigned LANES  = WLEN / DATA_WIDTH;
  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]                       state_q, state_d;
  logic [LANE_W-1:0]                lane_q, lane_d;
  logic [LANES-1:0][DATA_WIDTH-1:0] a_q, a_d;
  logic [LANES-1:0][DATA_WIDTH-1:0] b_q, b_d;
  logic [LANES-1:0][DATA_WIDTH-1:0] res_q, res_d;
  logic [DATA_WIDTH-1:0]            q_q, q_d;
  logic [LOG_R-1:0]                 q_dash_q, q_dash_d;
  logic                             bcast_q, bcast_d;
  logic                             run;

  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    q_d      = q_q;
    q_dash_d = q_dash_q;
    bcast_d  = bcast_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d      = bus.op0;
          b_d      = bus.op1;
          q_d      = bus.q;
          q_dash_d = bus.q_dash;
          bcast_d  = bus.bcast;
          lane_d   = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        // A missing grant leaves lane and operands untouched, so the request simply repeats.
        if (bus.mul_gnt) begin
          res_d[lane_q] = bus.mul_res;
          if (lane_q == LAST_LANE) begin
            lane_d  = '0;
            state_d = StDone;
          end else begin
            lane_d = lane_q + 1'b1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      lane_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      q_q      <= '0;
      q_dash_q <= '0;
      bcast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      q_q      <= q_d;
      q_dash_q <= q_dash_d;
      bcast_q  <= bcast_d;
    end
  end

  assign run = (state_q == StRun);

  assign bus.busy    = run;
  assign bus.done    = (state_q == StDone);
  assign bus.res     = res_q;
  assign bus.mul_req = run;

  // Multiplier operands are gated to zero outside RUN so idle cycles never toggle the shared unit.
  assign bus.mul_op0    = run ? a_q[lane_q] : '0;
  assign bus.mul_op1    = run ? (bcast_q ? b_q[0] : b_q[lane_q]) : '0;
  assign bus.mul_q      = run ? q_q : '0;
  assign bus.mul_q_dash = run ? q_dash_q : '0;
endmodule
